// File: rtl/adder_slice_scheduler_pkg.sv
// Shared types and constants for the byte-sliced adder scheduler.
package adder_slice_scheduler_pkg;

    localparam int SLICE = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_slice_scheduler_rca.sv
// 8-bit ripple-carry adder: the single arithmetic slice shared by the scheduler.
module ripple_carry_adder
    import adder_slice_scheduler_pkg::*;
(
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout
);

    logic [SLICE:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[SLICE];
    end

endmodule

// File: rtl/adder_slice_scheduler.sv
// Round-robin sharing of one 8-bit adder between two requesters; WIDTH-bit adds
// are sequenced one byte slice per cycle with the carry registered between slices.
module adder_slice_scheduler
    import adder_slice_scheduler_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin0,
    input  logic             cin1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             owner
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] opa, opb, res, res_nx;
    logic             carry;
    logic             last_grant;
    logic             gnt;
    logic             any_req;
    logic             last_slice;
    logic [SLICE-1:0] sl_a, sl_b, sl_s;
    logic             sl_co;

    assign any_req    = req0 | req1;
    assign last_slice = (idx == IDX_W'(N - 1));

    // On a tie the requester not granted last wins; otherwise the sole requester.
    assign gnt = (req0 && req1) ? ~last_grant : req1;

    always_comb begin
        sl_a   = opa[int'(idx) * SLICE +: SLICE];
        sl_b   = opb[int'(idx) * SLICE +: SLICE];
        res_nx = res;
        res_nx[int'(idx) * SLICE +: SLICE] = sl_s;
    end

    ripple_carry_adder u_rca (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .sum  (sl_s),
        .cout (sl_co)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (any_req) state_nx = S_RUN;
            S_RUN:   if (last_slice) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            sum        <= '0;
            cout       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        owner      <= gnt;
                        last_grant <= gnt;
                        carry      <= gnt ? cin1 : cin0;
                        idx        <= '0;
                    end
                end
                S_RUN: begin
                    carry <= sl_co;
                    idx   <= idx + 1'b1;
                    // Publish on the last slice so sum/cout are valid during DONE.
                    if (last_slice) begin
                        sum  <= res_nx;
                        cout <= sl_co;
                    end
                end
                default: ;
            endcase
        end
    end

    // Operand and partial-result storage carries data only; never reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && any_req) begin
            opa <= gnt ? a1 : a0;
            opb <= gnt ? b1 : b0;
        end
        if (state == S_RUN) begin
            res <= res_nx;
        end
    end

    assign busy  = (state != S_IDLE);
    assign done0 = (state == S_DONE) && !owner;
    assign done1 = (state == S_DONE) && owner;

endmodule

// File: tb/tb_adder_slice_scheduler.sv
// Directed bench for adder_slice_scheduler (WIDTH=32, four slices per add).
module tb_adder_slice_scheduler;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic        cin0, cin1;
    logic        done0, done1;
    logic [31:0] sum;
    logic        cout;
    logic        busy;
    logic        owner;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc;
    bit s0, s1;

    adder_slice_scheduler #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .cin0  (cin0),
        .cin1  (cin1),
        .done0 (done0),
        .done1 (done1),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .owner (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a done pulse (bounded); reports edges taken and which done fired.
    task automatic wait_done(output int c, output bit d0, output bit d1);
        c  = 0;
        d0 = 1'b0;
        d1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            c++;
            if (done0) d0 = 1'b1;
            if (done1) d1 = 1'b1;
            if (done0 || done1) break;
        end
    endtask

    initial begin
        rst  = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        cin0 = 1'b0; cin1 = 1'b0;
        step();
        step();

        check("rst_done0", done0, 0);
        check("rst_done1", done1, 0);
        check("rst_sum",   sum,   0);
        check("rst_cout",  cout,  0);
        check("rst_busy",  busy,  0);
        check("rst_owner", owner, 0);

        // Tie straight out of reset: requester 0 must win first.
        a0 = 32'h12345678; b0 = 32'h11111111;
        a1 = 32'h80000000; b1 = 32'h80000000;
        req0 = 1'b1; req1 = 1'b1;
        rst  = 1'b0;
        wait_done(cyc, s0, s1);
        check("tie_lat0",  cyc, 5);
        check("tie_done0", s0, 1);
        check("tie_nod1",  s1, 0);
        check("tie_sum0",  sum, 32'h23456789);
        check("tie_cout0", cout, 0);
        check("tie_own0",  owner, 0);
        check("tie_busy",  busy, 1);
        req0 = 1'b0;
        wait_done(cyc, s0, s1);
        check("tie_lat1",  cyc, 6);
        check("tie_done1", s1, 1);
        check("tie_nod0",  s0, 0);
        check("tie_sum1",  sum, 32'h00000000);
        check("tie_cout1", cout, 1);
        check("tie_own1",  owner, 1);

        // Second tie: requester 1 went last, so requester 0 wins again.
        a0 = 32'h00000001; b0 = 32'h00000002;
        req0 = 1'b1;
        wait_done(cyc, s0, s1);
        check("tie2_done0", s0, 1);
        check("tie2_nod1",  s1, 0);
        check("tie2_sum",   sum, 32'h00000003);
        req0 = 1'b0;
        wait_done(cyc, s0, s1);
        check("tie2_done1", s1, 1);
        check("tie2_sum1",  sum, 32'h00000000);
        req1 = 1'b0;
        step();
        check("pulse_one", done1, 0);
        check("sum_hold",  sum, 32'h00000000);

        // Small add on requester 0.
        a0 = 32'h000000FF; b0 = 32'h00000001; cin0 = 1'b0;
        req0 = 1'b1;
        wait_done(cyc, s0, s1);
        check("small_lat",  cyc, 5);
        check("small_d0",   s0, 1);
        check("small_nod1", s1, 0);
        check("small_sum",  sum, 32'h00000100);
        check("small_cout", cout, 0);
        req0 = 1'b0;
        step();
        check("small_pulse", done0, 0);
        check("small_idle",  busy, 0);

        // Carry ripples through every slice.
        a0 = 32'hFFFFFFFF; b0 = 32'h00000000; cin0 = 1'b1;
        req0 = 1'b1;
        wait_done(cyc, s0, s1);
        check("rip_d0",   s0, 1);
        check("rip_sum",  sum, 32'h00000000);
        check("rip_cout", cout, 1);
        req0 = 1'b0;
        step();

        // Operands change after grant; result must use the latched values.
        a0 = 32'h00000010; b0 = 32'h00000020; cin0 = 1'b0;
        req0 = 1'b1;
        step();
        a0 = 32'hDEADBEEF; b0 = 32'h01010101; cin0 = 1'b1;
        wait_done(cyc, s0, s1);
        check("stab_lat",  cyc, 4);
        check("stab_sum",  sum, 32'h00000030);
        check("stab_cout", cout, 0);
        req0 = 1'b0;
        step();

        // Reset during RUN aborts the add.
        a0 = 32'h00000005; b0 = 32'h00000006; cin0 = 1'b0;
        req0 = 1'b1;
        step();
        step();
        rst  = 1'b1;
        req0 = 1'b0;
        step();
        check("mrst_done0", done0, 0);
        check("mrst_done1", done1, 0);
        check("mrst_sum",   sum, 0);
        check("mrst_busy",  busy, 0);
        check("mrst_owner", owner, 0);
        rst = 1'b0;
        s0 = 1'b0; s1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done0 || done1) s0 = 1'b1;
        end
        check("mrst_nodone", s0, 0);
        a0 = 32'h00000007; b0 = 32'h00000008;
        req0 = 1'b1;
        wait_done(cyc, s0, s1);
        check("post_lat", cyc, 5);
        check("post_sum", sum, 32'h0000000F);
        req0 = 1'b0;
        step();

        // Back-to-back requests on requester 1.
        a1 = 32'h00000001; b1 = 32'h00000001; cin1 = 1'b0;
        req1 = 1'b1;
        wait_done(cyc, s0, s1);
        check("b2b_d1a",  s1, 1);
        check("b2b_suma", sum, 32'h00000002);
        check("b2b_owna", owner, 1);
        req1 = 1'b0;
        step();
        check("b2b_gap", busy, 0);
        a1 = 32'h00000064; b1 = 32'h000000C8;
        req1 = 1'b1;
        step();
        check("b2b_busy", busy, 1);
        wait_done(cyc, s0, s1);
        check("b2b_space", cyc + 2, 6);
        check("b2b_d1b",   s1, 1);
        check("b2b_sumb",  sum, 32'h0000012C);
        req1 = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
